// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and clamped step helper for the PWM duty ramp
package pwm_pkg;

    localparam int DUTY_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } ramp_state_t;

    // One bit of headroom so an up-step can't wrap and a down-step shows its borrow.
    function automatic logic [32:0] ramp_step(
        input logic [31:0] cur,
        input logic [31:0] tgt,
        input logic [31:0] step,
        input logic        up
    );
        logic [32:0] sum;
        if (up) begin
            sum = {1'b0, cur} + {1'b0, step};
            if (sum > {1'b0, tgt}) sum = {1'b0, tgt};
        end else begin
            sum = {1'b0, cur} - {1'b0, step};
            if (sum[32] || (sum < {1'b0, tgt})) sum = {1'b0, tgt};
        end
        return sum;
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// rtl/ramp_tick_gen.sv - step-interval prescaler producing a one-cycle tick
module ramp_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    assign tick = !clr && (cnt_q == rate_div);

    // A shrunk rate_div below cnt_q simply lets the counter wrap around.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - slew-rate limiter from SPI duty target to PWM duty input
module pwm_duty_ramp import pwm_pkg::*; #(
    parameter int DUTY_W = DUTY_W_DEFAULT,
    parameter int DIV_W  = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              ramp_en,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic [STEP_W-1:0] step_size,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              at_target
);

    ramp_state_t       state_q, state_d;
    logic [DUTY_W-1:0] target_q;
    logic [DUTY_W-1:0] duty_d;
    logic [DUTY_W-1:0] stepped;
    logic [STEP_W-1:0] step_eff;
    logic              tick;
    logic              clr;

    assign clr       = !ramp_en || (state_q == IDLE);
    assign step_eff  = (step_size == '0) ? STEP_W'(1) : step_size;
    assign stepped   = DUTY_W'(ramp_step(32'(duty_out), 32'(target_q), 32'(step_eff),
                                         state_q == RAMP_UP));
    assign busy      = (state_q != IDLE);
    assign at_target = (duty_out == target_q);

    ramp_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .rate_div (rate_div),
        .tick     (tick)
    );

    // A target that crosses duty_out only flips direction; the step waits a cycle.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_out;
        if (!ramp_en) begin
            state_d = IDLE;
            duty_d  = target_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (target_q > duty_out)      state_d = RAMP_UP;
                    else if (target_q < duty_out) state_d = RAMP_DOWN;
                end
                RAMP_UP: begin
                    if (target_q == duty_out)     state_d = IDLE;
                    else if (target_q < duty_out) state_d = RAMP_DOWN;
                    else if (tick) begin
                        duty_d = stepped;
                        if (stepped == target_q) state_d = IDLE;
                    end
                end
                RAMP_DOWN: begin
                    if (target_q == duty_out)     state_d = IDLE;
                    else if (target_q > duty_out) state_d = RAMP_UP;
                    else if (tick) begin
                        duty_d = stepped;
                        if (stepped == target_q) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            duty_out <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_duty;
            duty_out <= duty_d;
        end
    end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Slew-rate limiter between the SPI register file and the PWM peripheral. It takes the SPI-written duty-cycle register as a target and drives the PWM duty input toward it in bounded steps at a programmable rate, so motor and LED loads never see abrupt duty jumps. When ramping is disabled it is a one-cycle-latency pass-through.

Parameters:
- DUTY_W, 8, duty width; matches the PWM duty register.
- DIV_W, 16, width of the step-interval divider.
- STEP_W, 4, width of the step-size input.

Ports:
- clk  input  1  system clock, single domain.
- rst  input  1  synchronous, active-high reset.
- target_duty  input  DUTY_W  target duty from the SPI register file; may change on any cycle.
- ramp_en  input  1  1 = slew-limit, 0 = pass-through.
- rate_div  input  DIV_W  clocks between steps minus 1; 0 = step every clock.
- step_size  input  STEP_W  duty increment per step; 0 is treated as 1.
- duty_out  output  DUTY_W  duty value driven to the PWM peripheral.
- busy  output  1  high while ramping (state != IDLE).
- at_target  output  1  high when duty_out == target_q.

Behaviour:
- Reset (clk edge with rst=1):
  - target_q = 0, duty_out = 0, prescaler = 0, state = IDLE.
  - Outputs after reset: busy = 0, at_target = 1.
  - Reset mid-ramp aborts the ramp immediately with the same values.
- Input registering: target_duty is registered into target_q every cycle. All decisions use target_q, never target_duty directly.
- States: IDLE, RAMP_UP, RAMP_DOWN.
- Pass-through (ramp_en=0):
  - duty_out <= target_q every cycle; state forced to IDLE; prescaler cleared.
  - Total latency from target_duty to duty_out is 2 edges.
  - ramp_en dropping mid-ramp: the next edge loads duty_out = target_q and goes to IDLE.
- IDLE (ramp_en=1):
  - If target_q > duty_out, go to RAMP_UP; if target_q < duty_out, go to RAMP_DOWN.
  - The entry edge clears the prescaler. duty_out is unchanged on that edge.
- RAMP_UP / RAMP_DOWN, stepping:
  - The prescaler increments each cycle. When prescaler == rate_div, the step fires and the prescaler returns to 0.
  - On a step: duty_out <= duty_out ± max(step_size, 1).
  - Arithmetic is done in DUTY_W+1 bits and clamped to target_q, so duty_out never overshoots, underflows below 0, or exceeds 2^DUTY_W−1.
- Step timing: if the IDLE→RAMP edge is E1, steps land on edges E1 + k·(rate_div+1), for k = 1, 2, …
- Leaving RAMP: on the step edge where duty_out becomes equal to target_q, the state returns to IDLE.
- Target moves during a ramp:
  - Same side: continue with the prescaler untouched.
  - Crosses to the other side of duty_out: the direction changes on the next cycle (RAMP_UP↔RAMP_DOWN) without resetting the prescaler.
  - Becomes equal to duty_out: return to IDLE on the next edge with no step.
- rate_div changes mid-ramp:
  - Takes effect at the next compare.
  - If the prescaler already exceeds the new rate_div, it keeps counting and wraps at 2^DIV_W; this is legal and needs no special handling.
- Output decode: busy and at_target are combinational decodes of registered state. duty_out is a direct register output.

Decomposition:
- Shared package pwm_pkg:
  - DUTY_W default constant.
  - ramp_state_t enum {IDLE, RAMP_UP, RAMP_DOWN}.
  - Saturating add/subtract-with-clamp function.
- One natural sub-module: ramp_tick_gen, the prescaler.
  - Inputs: clk, rst, clr, rate_div.
  - Output: a single-cycle tick pulse.

Test Plan:
- Reset: hold rst for 3 cycles while driving target_duty=0xAA -> duty_out=0x00, busy=0, at_target=1 on the first cycle after release.
- Pass-through: ramp_en=0, target_duty 0x00→0x80 at edge E0 -> duty_out=0x80 at E2; busy stays 0 throughout.
- Basic ramp up: ramp_en=1, rate_div=3, step_size=1, target 0→4 -> duty_out reaches 1, 2, 3, 4 at E1+4, +8, +12, +16; busy falls on the same edge duty_out reaches 4; at_target=1 after.
- Clamp, no overshoot: rate_div=0, step_size=15, duty 0xF0 → target 0xFF -> 0xFF on the first step.
  - Separately, duty 0x05 → target 0x00 -> 0x00 on the first step, with no wrap to 0xF6.
- Mid-ramp reversal: ramping up 0x10→0x40 with step 1 and rate_div=0; at duty 0x20 set target 0x18 -> direction flips, duty_out descends 0x1F…0x18, then IDLE.
- Abort paths: mid-ramp drop ramp_en -> duty_out = target_q the next edge.
  - Separately, mid-ramp assert rst -> duty_out=0 and IDLE on that edge.
